// File: rtl/game_pkg.sv
// Shared types and constants for the song sequencer: state encoding, difficulty
// limits and the per-song segment-count table.
package game_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNTDOWN,
      PLAY,
      DRAIN,
      DONE
   } seq_state_t;

   localparam int NUM_SONGS       = 4;
   localparam int MAX_SEGS        = 16;
   localparam int COUNTDOWN_BEATS = 4;
   localparam int DRAIN_BEATS     = 40;
   localparam int SEG_W           = 32;

   localparam logic [22:0] EASY_LIM = 23'd6_000_000;
   localparam logic [22:0] HARD_LIM = 23'd3_000_000;

   // Index of the final segment for each song; element 0 is the rightmost nibble.
   typedef logic [NUM_SONGS-1:0][3:0] song_len_t;
   localparam song_len_t SONG_LAST = {4'd2, 4'd0, 4'd1, 4'd3};

endpackage

// File: rtl/song_sequencer_if.sv
// Bundle between the upstream controller (master) and the song sequencer (slave).
interface song_sequencer_if;
   import game_pkg::*;

   logic             start;
   logic             abort;
   logic [2:0]       mode;
   logic             beat_clk;
   logic [SEG_W-1:0] notes1;
   logic [SEG_W-1:0] notes2;
   logic [22:0]      diff;
   logic             playing;
   logic             song_done;
   logic [3:0]       seg_idx;
   logic [5:0]       beat_idx;

   modport master (
      output start, abort, mode, beat_clk,
      input  notes1, notes2, diff, playing, song_done, seg_idx, beat_idx
   );

   modport slave (
      input  start, abort, mode, beat_clk,
      output notes1, notes2, diff, playing, song_done, seg_idx, beat_idx
   );

endinterface

// File: rtl/song_rom.sv
// Combinational song ROM: two lane words per 32-beat segment plus the song's
// final segment index.
module song_rom
   import game_pkg::*;
(
   input  logic [1:0]       song,
   input  logic [3:0]       seg,
   output logic [SEG_W-1:0] lane1,
   output logic [SEG_W-1:0] lane2,
   output logic [3:0]       last_seg
);

   assign last_seg = SONG_LAST[song];

   // Unlisted song/segment pairs read as silence.
   always_comb begin
      lane1 = '0;
      lane2 = '0;
      case ({song, seg})
         {2'd0, 4'd0}: begin lane1 = 32'h8888_8888; lane2 = 32'h1111_1111; end
         {2'd0, 4'd1}: begin lane1 = 32'hF0F0_F0F0; lane2 = 32'h0F0F_0F0F; end
         {2'd0, 4'd2}: begin lane1 = 32'hAAAA_5555; lane2 = 32'h5555_AAAA; end
         {2'd0, 4'd3}: begin lane1 = 32'hFF00_FF00; lane2 = 32'h00FF_00FF; end
         {2'd1, 4'd0}: begin lane1 = 32'h1234_5678; lane2 = 32'h8765_4321; end
         {2'd1, 4'd1}: begin lane1 = 32'hDEAD_BEEF; lane2 = 32'hCAFE_F00D; end
         {2'd2, 4'd0}: begin lane1 = 32'hC3C3_C3C3; lane2 = 32'h3C3C_3C3C; end
         {2'd3, 4'd0}: begin lane1 = 32'h0001_8000; lane2 = 32'h8000_0001; end
         {2'd3, 4'd1}: begin lane1 = 32'h0F00_00F0; lane2 = 32'hF000_000F; end
         {2'd3, 4'd2}: begin lane1 = 32'h9999_6666; lane2 = 32'h6666_9999; end
         default:      begin lane1 = '0;           lane2 = '0;           end
      endcase
   end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: picks a song and difficulty on start, then streams 32-beat
// note segments to the gameplay core through countdown, play and drain phases.
module song_sequencer
   import game_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   song_sequencer_if.slave bus
);

   seq_state_t       state;
   logic [1:0]       song;
   logic [3:0]       last_seg;
   logic [SEG_W-1:0] notes1;
   logic [SEG_W-1:0] notes2;
   logic [22:0]      diff;
   logic             playing;
   logic             song_done;
   logic [3:0]       seg_idx;
   logic [5:0]       beat_idx;

   logic [1:0]       rom_song;
   logic [3:0]       rom_seg;
   logic [SEG_W-1:0] rom_lane1;
   logic [SEG_W-1:0] rom_lane2;
   logic [3:0]       rom_last;

   logic idle_like;
   assign idle_like = (state == IDLE) || (state == DONE);

   // While waiting for start the ROM looks at the live mode so the length can be
   // latched; once running it follows the latched song and the next segment.
   always_comb begin
      rom_song = idle_like ? bus.mode[1:0] : song;
      rom_seg  = (state == PLAY) ? seg_idx + 4'd1 : 4'd0;
   end

   song_rom u_rom (
      .song     (rom_song),
      .seg      (rom_seg),
      .lane1    (rom_lane1),
      .lane2    (rom_lane2),
      .last_seg (rom_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         song      <= 2'd0;
         last_seg  <= 4'd0;
         notes1    <= '0;
         notes2    <= '0;
         diff      <= EASY_LIM;
         playing   <= 1'b0;
         song_done <= 1'b0;
         seg_idx   <= 4'd0;
         beat_idx  <= 6'd0;
      end else if (idle_like) begin
         if (bus.start) begin
            song      <= bus.mode[1:0];
            diff      <= bus.mode[2] ? HARD_LIM : EASY_LIM;
            last_seg  <= rom_last;
            seg_idx   <= 4'd0;
            beat_idx  <= 6'd0;
            notes1    <= '0;
            notes2    <= '0;
            playing   <= 1'b1;
            song_done <= 1'b0;
            state     <= COUNTDOWN;
         end
      end else if (bus.abort) begin
         notes1   <= '0;
         notes2   <= '0;
         seg_idx  <= 4'd0;
         beat_idx <= 6'd0;
         playing  <= 1'b0;
         state    <= IDLE;
      end else if (bus.beat_clk) begin
         case (state)
            COUNTDOWN: begin
               if (beat_idx == 6'(COUNTDOWN_BEATS - 1)) begin
                  notes1   <= rom_lane1;
                  notes2   <= rom_lane2;
                  beat_idx <= 6'd0;
                  state    <= PLAY;
               end else begin
                  beat_idx <= beat_idx + 6'd1;
               end
            end
            PLAY: begin
               if (beat_idx == 6'd31) begin
                  beat_idx <= 6'd0;
                  if (seg_idx < last_seg) begin
                     seg_idx <= seg_idx + 4'd1;
                     notes1  <= rom_lane1;
                     notes2  <= rom_lane2;
                  end else begin
                     notes1 <= '0;
                     notes2 <= '0;
                     state  <= DRAIN;
                  end
               end else begin
                  beat_idx <= beat_idx + 6'd1;
               end
            end
            DRAIN: begin
               // beat_idx stays at its final value so the display can show it in DONE.
               if (beat_idx == 6'(DRAIN_BEATS - 1)) begin
                  playing   <= 1'b0;
                  song_done <= 1'b1;
                  state     <= DONE;
               end else begin
                  beat_idx <= beat_idx + 6'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.notes1    = notes1;
   assign bus.notes2    = notes2;
   assign bus.diff      = diff;
   assign bus.playing   = playing;
   assign bus.song_done = song_done;
   assign bus.seg_idx   = seg_idx;
   assign bus.beat_idx  = beat_idx;

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Upstream feeder for the gameplay core: selects a song and difficulty, then streams 32-beat note segments for both lanes into the core's notes1/notes2 inputs.
- Advances on the core's beat_clk pulse. Runs countdown, play and drain phases, then flags song completion to the top-level and display logic.
- Owns the song ROM (sub-module) and the difficulty-to-clock-divider-limit mapping.

Parameters:
- NUM_SONGS, 4, songs in ROM; song index = mode[1:0]
- MAX_SEGS, 16, maximum 32-beat segments per song
- COUNTDOWN_BEATS, 4, silent beats after start before segment 0 is presented
- DRAIN_BEATS, 40, silent beats after the last segment so padded notes scroll off
- EASY_LIM, 23'd6_000_000, diff value when mode[2]=0
- HARD_LIM, 23'd3_000_000, diff value when mode[2]=1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle start pulse (already edge-synced upstream)
- abort  in  1  single-cycle abort pulse
- mode  in  3  [1:0] song select, [2] hard difficulty
- beat_clk  in  1  single-cycle beat pulse from gameplay core
- notes1  out  32  lane-1 segment to core
- notes2  out  32  lane-2 segment to core
- diff  out  23  clock-divider limit to core
- playing  out  1  high in COUNTDOWN/PLAY/DRAIN
- song_done  out  1  high in DONE
- seg_idx  out  4  current segment index
- beat_idx  out  6  beat counter within current phase

Behaviour:
- Reset: state=IDLE, notes1=notes2=0, diff=EASY_LIM, seg_idx=0, beat_idx=0, playing=0, song_done=0. Reset dominates every other input in all states.
- All outputs are registered. ROM read is combinational; its result is captured into notes1/notes2 on the same edge the index advances, so there is 0 extra latency.
- States: IDLE, COUNTDOWN, PLAY, DRAIN, DONE.
- IDLE/DONE + start:
  - Latch song = mode[1:0].
  - diff <= mode[2] ? HARD_LIM : EASY_LIM.
  - Latch last_seg from the ROM length table.
  - seg_idx=0, beat_idx=0, notes=0, go to COUNTDOWN.
  - mode changes at any later time are ignored until the next start.
- COUNTDOWN: each beat_clk increments beat_idx. The beat_clk at beat_idx==COUNTDOWN_BEATS-1 loads notes <= ROM[song,0], clears beat_idx and goes to PLAY.
- PLAY: each beat_clk increments beat_idx mod 32. The beat_clk at beat_idx==31 does one of two things:
  - seg_idx<last_seg: seg_idx++, notes <= ROM[song, seg_idx+1], beat_idx=0.
  - seg_idx==last_seg: notes=0, beat_idx=0, go to DRAIN.
- DRAIN: each beat_clk increments beat_idx. The beat_clk at beat_idx==DRAIN_BEATS-1 goes to DONE and holds notes=0.
- DONE: song_done=1 until start (restart) or reset. seg_idx and beat_idx are held for display.
- abort in COUNTDOWN/PLAY/DRAIN: go to IDLE, notes=0, seg_idx=0, beat_idx=0, diff held. abort in IDLE/DONE has no effect.
- Simultaneous events:
  - abort and beat_clk in the same cycle: abort wins.
  - start outside IDLE/DONE: ignored.
  - start and abort in the same cycle: abort wins (start is already ignored in active states).
- beat_clk in IDLE/DONE is ignored.
- A single-segment song (last_seg=0) goes PLAY -> DRAIN after 32 beats.
- seg_idx never exceeds last_seg (no wrap).

Decomposition:
- Shared package game_pkg:
  - state enum seq_state_t.
  - EASY_LIM/HARD_LIM constants.
  - SEG_W=32.
  - song length table type (NUM_SONGS x 4-bit last_seg).
- Sub-module song_rom: combinational. Inputs song[1:0] and seg[3:0]. Outputs lane1[31:0], lane2[31:0] and last_seg[3:0]. Contents are a case table.
- The sequencer FSM and counters live in song_sequencer.

Test Plan:
- Reset mid-PLAY (seg_idx=2, beat_idx=17), rst high 1 cycle -> next cycle state IDLE, notes=0, seg_idx=0, beat_idx=0, diff=EASY_LIM, playing=0.
- mode=3'b101, start, then 4 beat_clk -> diff=HARD_LIM after start. notes=0 through beats 0-3. After the 4th beat, notes1/notes2 equal song 1 segment 0 ROM words and playing=1.
- Song with last_seg=1: start, 4 + 32 beats -> seg_idx=1 and notes=ROM[song,1]. 32 more beats -> notes=0, DRAIN. 40 more beats -> song_done=1, playing=0.
- abort asserted together with the beat_clk at beat_idx==31 in PLAY -> IDLE, seg_idx stays 0 then reset to 0, no segment load, notes=0.
- In PLAY, change mode to 3'b010 and pulse start -> no effect: song, diff and notes unchanged, beat sequence continues.
- DONE, then start with mode=3'b000 -> COUNTDOWN, song_done=0, seg_idx=0, diff=EASY_LIM.
